mips_bus_ram: RTL and testbench

MIPS_BUS_RAM -- requirements
Module: mips_bus_ram

---
 rtl/mips_bus_ram.sv | 154 +++++++++++++++
 tb/tb_mips_bus_ram.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_ram.sv
// Avalon-MM word RAM for a MIPS boot region, with fixed wait states and sticky error reporting.
// Define MIPS_BUS_RAM_RANDOM_WAIT_EN to add 0-3 LFSR-driven wait states per transfer.
module mips_bus_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        error
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [4:0]  wait_cnt_reg;
    logic [31:0] readdata_reg;
    logic        error_reg;

    logic                 request;
    logic [31:0]          offset;
    logic                 in_range;
    logic                 aligned;
    logic                 legal;
    logic [ADDR_BITS-1:0] word_idx;
    logic [4:0]           eff_wait;
    logic                 enter_ack;
    logic                 mem_we;
    logic [31:0]          lane_rdata;

    assign request = read | write;

    // Offset wraps for addresses below the base; the explicit >= check rejects those.
    assign offset   = address - BASE_ADDR;
    assign in_range = (address >= BASE_ADDR) && ((offset >> (ADDR_BITS + 2)) == 32'd0);
    assign aligned  = (address[1:0] == 2'b00);
    assign legal    = in_range && aligned && !(read && write);
    assign word_idx = offset[ADDR_BITS+1:2];

`ifdef MIPS_BUS_RAM_RANDOM_WAIT_EN
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;
    logic        xfer_start;

    assign lfsr_fb    = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    assign xfer_start = (state_reg == IDLE) && request;
    assign eff_wait   = 5'(WAIT_CYCLES) + {3'b000, lfsr_reg[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_reg <= 16'hACE1;
        end else if (xfer_start) begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end
`else
    assign eff_wait = 5'(WAIT_CYCLES);
`endif

    // The cycle on which the FSM commits to ACK is where read data and errors are captured.
    always_comb begin
        enter_ack = 1'b0;
        case (state_reg)
            IDLE:    enter_ack = request && (eff_wait == 5'd0);
            WAIT:    enter_ack = request && (wait_cnt_reg == 5'd1);
            default: enter_ack = 1'b0;
        endcase
    end

    assign mem_we = (state_reg == ACK) && write && legal;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (mem_we && byteenable[gi]) begin
                    lane_mem[word_idx] <= writedata[8*gi +: 8];
                end
            end

            assign lane_rdata[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 5'd0;
            readdata_reg <= 32'h0000_0000;
            error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (request) begin
                        if (eff_wait == 5'd0) begin
                            state_reg <= ACK;
                        end else begin
                            state_reg    <= WAIT;
                            wait_cnt_reg <= eff_wait;
                        end
                    end
                end
                WAIT: begin
                    // A master that withdraws its request abandons the transfer silently.
                    if (!request) begin
                        state_reg    <= IDLE;
                        wait_cnt_reg <= 5'd0;
                    end else if (wait_cnt_reg == 5'd1) begin
                        state_reg    <= ACK;
                        wait_cnt_reg <= 5'd0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 5'd1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg    <= IDLE;
                    wait_cnt_reg <= 5'd0;
                end
            endcase

            if (enter_ack) begin
                if (read) begin
                    readdata_reg <= legal ? lane_rdata : 32'h0000_0000;
                end
                if (!legal) begin
                    error_reg <= 1'b1;
                end
            end
        end
    end

    assign waitrequest = request && (state_reg != ACK);
    assign readdata    = readdata_reg;
    assign error       = error_reg;

endmodule

// File: tb/tb_mips_bus_ram.sv
// Randomised self-checking bench for mips_bus_ram against a byte-addressed memory model.
module tb_mips_bus_ram;

    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam int          AB   = 10;
    localparam int          WC   = 1;
    localparam int          TMO  = 64;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model_mem [longint];
    logic       err_exp;

    mips_bus_ram #(
        .BASE_ADDR  (BASE),
        .ADDR_BITS  (AB),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .byteenable (byteenable),
        .waitrequest(waitrequest),
        .readdata   (readdata),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_legal(input logic [31:0] a, input logic rd, input logic wr);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * (longint'(1) << AB))
               && (a % 4 == 0) && !(rd && wr);
    endfunction

    function automatic bit lat_ok(input int lat);
`ifdef MIPS_BUS_RAM_RANDOM_WAIT_EN
        return (lat >= 1 + WC) && (lat <= 4 + WC);
`else
        return lat == 1 + WC;
`endif
    endfunction

    // Expected read result: assembled from the byte model, zero for any illegal transfer.
    function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd, input logic wr);
        logic [31:0] r;
        r = 32'h0;
        if (model_legal(a, rd, wr)) begin
            for (int i = 0; i < 4; i++) begin
                if (model_mem.exists(longint'(a) + i)) r[8*i +: 8] = model_mem[longint'(a) + i];
            end
        end
        return r;
    endfunction

    task automatic model_update(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be);
        if (!model_legal(a, rd, wr)) begin
            err_exp = 1'b1;
        end else if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model_mem[longint'(a) + i] = d[8*i +: 8];
            end
        end
    endtask

    // Called on a falling edge; returns on a falling edge with the bus idle.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rdata, output int lat, output logic err);
        read = rd; write = wr; address = a; writedata = d; byteenable = be;
        lat = 0;
        #1;
        while (waitrequest === 1'b1 && lat < TMO) begin
            @(negedge clk); #1;
            lat++;
        end
        if (lat >= TMO) begin
            n_checks++;
            $display("FAIL timeout addr=%h waitrequest stuck at %b after %0d cycles, required 0", a, waitrequest, lat);
        end
        rdata = readdata;
        err   = error;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        $display("xfer rd=%0b wr=%0b addr=%h wdata=%h be=%b -> rdata=%h lat=%0d err=%0b",
                 rd, wr, a, d, be, rdata, lat, err);
    endtask

    task automatic test_reset;
        reset = 1'b0; read = 1'b0; write = 1'b0;
        address = 32'h0; writedata = 32'h0; byteenable = 4'h0;
        err_exp = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (waitrequest !== 1'b0) $display("FAIL reset_wait got %b need 0", waitrequest); else n_pass++;
        n_checks++;
        if (readdata !== 32'h0) $display("FAIL reset_rdata got %h need 00000000", readdata); else n_pass++;
        n_checks++;
        if (error !== 1'b0) $display("FAIL reset_err got %b need 0", error); else n_pass++;
        read = 1'b1; #1;
        n_checks++;
        if (waitrequest !== 1'b1) $display("FAIL reset_wait_req got %b need 1", waitrequest); else n_pass++;
        read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        logic [31:0] rd; int lat; logic err;
        xfer(1'b0, 1'b1, 32'hBFC00004, 32'h12345678, 4'hF, rd, lat, err);
        model_update(1'b0, 1'b1, 32'hBFC00004, 32'h12345678, 4'hF);
        n_checks++;
        if (!lat_ok(lat)) $display("FAIL wr_latency got %0d need %0d", lat, 1 + WC); else n_pass++;
        xfer(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0, rd, lat, err);
        n_checks++;
        if (!lat_ok(lat)) $display("FAIL rd_latency got %0d need %0d", lat, 1 + WC); else n_pass++;
        n_checks++;
        if (rd !== 32'h12345678) $display("FAIL rd_data got %h need 12345678", rd); else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL rd_err got %b need 0", err); else n_pass++;
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd; int lat; logic err;
        logic [31:0] wd [4] = '{32'hFFFFFFFF, 32'h000000AA, 32'h11223344, 32'h5566_7788};
        logic [3:0]  bes [4] = '{4'hF, 4'b0001, 4'b0000, 4'b1010};
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 1'b1, 32'hBFC00008, wd[i], bes[i], rd, lat, err);
            model_update(1'b0, 1'b1, 32'hBFC00008, wd[i], bes[i]);
            xfer(1'b1, 1'b0, 32'hBFC00008, 32'h0, 4'h0, rd, lat, err);
            n_checks++;
            if (rd !== model_read(32'hBFC00008, 1'b1, 1'b0))
                $display("FAIL lane_data[%0d] got %h need %h", i, rd, model_read(32'hBFC00008, 1'b1, 1'b0));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, a, d, exp; int lat; logic err; logic op; logic [3:0] be;
        for (int w = 0; w < 16; w++) begin
            a = BASE + 32'(4 * w);
            d = $urandom;
            xfer(1'b0, 1'b1, a, d, 4'hF, rd, lat, err);
            model_update(1'b0, 1'b1, a, d, 4'hF);
        end
        for (int t = 0; t < 50; t++) begin
            op = 1'($urandom_range(0, 1));
            a  = BASE + 32'(4 * $urandom_range(0, 15));
            d  = $urandom;
            be = 4'($urandom);
            exp = model_read(a, op, !op);
            xfer(op, !op, a, d, be, rd, lat, err);
            model_update(op, !op, a, d, be);
            n_checks++;
            if (!lat_ok(lat)) $display("FAIL b2b_latency[%0d] got %0d need %0d", t, lat, 1 + WC); else n_pass++;
            n_checks++;
            if (err !== 1'b0) $display("FAIL b2b_err[%0d] got %b need 0", t, err); else n_pass++;
            if (op) begin
                n_checks++;
                if (rd !== exp) $display("FAIL b2b_data[%0d] got %h need %h", t, rd, exp); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; int lat; logic err;
        xfer(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0, rd, lat, err);
        read = 1'b0; write = 1'b1; address = 32'hBFC00000; writedata = 32'hDEADBEEF; byteenable = 4'hF;
        @(negedge clk); #1;
        reset = 1'b0; #1;
        n_checks++;
        if (waitrequest !== 1'b1) $display("FAIL abort_wait_req got %b need 1", waitrequest); else n_pass++;
        n_checks++;
        if (readdata !== 32'h0) $display("FAIL abort_rdata got %h need 00000000", readdata); else n_pass++;
        write = 1'b0; #1;
        n_checks++;
        if (waitrequest !== 1'b0) $display("FAIL abort_wait_idle got %b need 0", waitrequest); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xfer(1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'h0, rd, lat, err);
        n_checks++;
        if (!lat_ok(lat)) $display("FAIL abort_latency got %0d need %0d", lat, 1 + WC); else n_pass++;
        n_checks++;
        if (rd !== model_read(32'hBFC00000, 1'b1, 1'b0))
            $display("FAIL abort_word got %h need %h", rd, model_read(32'hBFC00000, 1'b1, 1'b0));
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL abort_err got %b need 0", err); else n_pass++;
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; int lat; logic err;
        logic [31:0] addrs [4] = '{32'h00000000, 32'hBFC00006, 32'hBFC01000, 32'hBFBFFFFC};
        xfer(1'b0, 1'b1, 32'hBFC00004, 32'hCAFEF00D, 4'hF, rd, lat, err);
        model_update(1'b0, 1'b1, 32'hBFC00004, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0, rd, lat, err);
            n_checks++;
            if (rd !== 32'hCAFEF00D) $display("FAIL oor_prior[%0d] got %h need cafef00d", i, rd); else n_pass++;
            xfer(1'b0, 1'b1, addrs[i], 32'h0BADF00D, 4'hF, rd, lat, err);
            model_update(1'b0, 1'b1, addrs[i], 32'h0BADF00D, 4'hF);
            xfer(1'b1, 1'b0, addrs[i], 32'h0, 4'h0, rd, lat, err);
            model_update(1'b1, 1'b0, addrs[i], 32'h0, 4'h0);
            n_checks++;
            if (!lat_ok(lat)) $display("FAIL oor_latency[%0d] got %0d need %0d", i, lat, 1 + WC); else n_pass++;
            n_checks++;
            if (rd !== 32'h0) $display("FAIL oor_rdata[%0d] got %h need 00000000", i, rd); else n_pass++;
            n_checks++;
            if (err !== err_exp) $display("FAIL oor_err[%0d] got %b need %b", i, err, err_exp); else n_pass++;
        end
        xfer(1'b1, 1'b0, 32'hBFC00008, 32'h0, 4'h0, rd, lat, err);
        n_checks++;
        if (err !== err_exp) $display("FAIL err_sticky got %b need %b", err, err_exp); else n_pass++;
    endtask

    task automatic test_rw_both;
        logic [31:0] rd; int lat; logic err;
        xfer(1'b0, 1'b1, 32'hBFC00010, 32'hA5A55A5A, 4'hF, rd, lat, err);
        model_update(1'b0, 1'b1, 32'hBFC00010, 32'hA5A55A5A, 4'hF);
        xfer(1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'h0, rd, lat, err);
        xfer(1'b1, 1'b1, 32'hBFC00010, 32'h01020304, 4'hF, rd, lat, err);
        model_update(1'b1, 1'b1, 32'hBFC00010, 32'h01020304, 4'hF);
        n_checks++;
        if (!lat_ok(lat)) $display("FAIL both_latency got %0d need %0d", lat, 1 + WC); else n_pass++;
        n_checks++;
        if (rd !== 32'h0) $display("FAIL both_rdata got %h need 00000000", rd); else n_pass++;
        n_checks++;
        if (err !== 1'b1) $display("FAIL both_err got %b need 1", err); else n_pass++;
        xfer(1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'h0, rd, lat, err);
        n_checks++;
        if (rd !== model_read(32'hBFC00010, 1'b1, 1'b0))
            $display("FAIL both_nochange got %h need %h", rd, model_read(32'hBFC00010, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_error_clear;
        @(negedge clk);
        reset = 1'b0; #1;
        err_exp = 1'b0;
        n_checks++;
        if (error !== 1'b0) $display("FAIL err_clear got %b need 0", error); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

`ifdef MIPS_BUS_RAM_RANDOM_WAIT_EN
    task automatic test_random_wait;
        logic [31:0] rd; int lat; logic err; logic [3:0] seen;
        seen = 4'h0;
        for (int t = 0; t < 100; t++) begin
            xfer(1'b1, 1'b0, BASE + 32'(4 * $urandom_range(0, 15)), 32'h0, 4'h0, rd, lat, err);
            n_checks++;
            if (!lat_ok(lat)) $display("FAIL rnd_latency[%0d] got %0d need %0d..%0d", t, lat, 1 + WC, 4 + WC);
            else begin
                n_pass++;
                seen[lat - 1 - WC] = 1'b1;
            end
        end
        n_checks++;
        if (seen !== 4'hF) $display("FAIL rnd_coverage got %b need 1111", seen); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_reset_mid();
`ifdef MIPS_BUS_RAM_RANDOM_WAIT_EN
        test_random_wait();
`endif
        test_out_of_range();
        test_rw_both();
        test_error_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
